// File: rtl/ctrl_pkg.sv
// Shared opcode/function encodings, ALU codes, FSM states and the control bundle
// type for the registered control decoder.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SRL     = 6'b000010;
    localparam logic [5:0] FN_SRA     = 6'b000011;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_XOR     = 6'b100110;
    localparam logic [5:0] FN_NOR     = 6'b100111;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLTU    = 6'b101011;

    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_ADDU = 6'b100001;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_XOR  = 6'b100110;
    localparam logic [5:0] ALU_SLT  = 6'b101010;
    localparam logic [5:0] ALU_LUI  = 6'b111101;
    localparam logic [5:0] ALU_BEQ  = 6'b111000;
    localparam logic [5:0] ALU_BNE  = 6'b111001;
    localparam logic [5:0] ALU_BLEZ = 6'b111010;
    localparam logic [5:0] ALU_BGTZ = 6'b111011;
    localparam logic [5:0] ALU_BGEZ = 6'b111100;

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_MULDIV_WAIT = 2'd1,
        ST_DRAIN       = 2'd2,
        ST_HALTED      = 2'd3
    } state_e;

    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_write_en;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [5:0] alu_op;
        logic       link;
        logic       mem_byte;
        logic       illegal;
    } ctrl_bundle_t;

    function automatic logic rfunc_legal(input logic [5:0] fn);
        case (fn)
            FN_SLL, FN_SRL, FN_SRA, FN_SYSCALL, FN_MULT, FN_DIV,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
            FN_XOR, FN_NOR, FN_SLT, FN_SLTU: rfunc_legal = 1'b1;
            default:                         rfunc_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/func decode into a control bundle, plus flags that
// steer the MULT/DIV stall and SYSCALL drain sequences.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic [5:0]   inst_i,
    input  logic [5:0]   func_i,
    output ctrl_bundle_t ctrl_o,
    output logic         is_muldiv_o,
    output logic         is_syscall_o
);

    logic md_fn;
    assign md_fn = (func_i == FN_MULT) || (func_i == FN_DIV);

    always_comb begin
        ctrl_o       = '0;
        is_muldiv_o  = 1'b0;
        is_syscall_o = 1'b0;
        case (inst_i)
            OP_RTYPE: begin
                if (!rfunc_legal(func_i) || (md_fn && !ENABLE_MULDIV)) begin
                    ctrl_o.illegal = 1'b1;
                end else begin
                    ctrl_o.reg_dst   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_op    = func_i;
                    if (func_i == FN_SYSCALL) begin
                        ctrl_o.reg_write = 1'b0;
                        ctrl_o.alu_op    = '0;
                        is_syscall_o     = 1'b1;
                    end else if (md_fn) begin
                        ctrl_o.reg_write = 1'b0;
                        is_muldiv_o      = 1'b1;
                    end
                end
            end
            OP_J: begin
                ctrl_o.jump   = 1'b1;
                ctrl_o.alu_op = ALU_ADD;
            end
            OP_JAL: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.link      = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_ADD;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                case (inst_i)
                    OP_ADDI:  ctrl_o.alu_op = ALU_ADD;
                    OP_ADDIU: ctrl_o.alu_op = ALU_ADDU;
                    OP_SLTI:  ctrl_o.alu_op = ALU_SLT;
                    OP_ANDI:  ctrl_o.alu_op = ALU_AND;
                    OP_ORI:   ctrl_o.alu_op = ALU_OR;
                    OP_XORI:  ctrl_o.alu_op = ALU_XOR;
                    default:  ctrl_o.alu_op = ALU_LUI;
                endcase
            end
            OP_BEQ:  begin ctrl_o.branch = 1'b1; ctrl_o.alu_op = ALU_BEQ;  end
            OP_BNE:  begin ctrl_o.branch = 1'b1; ctrl_o.alu_op = ALU_BNE;  end
            OP_BLEZ: begin ctrl_o.branch = 1'b1; ctrl_o.alu_op = ALU_BLEZ; end
            OP_BGTZ: begin ctrl_o.branch = 1'b1; ctrl_o.alu_op = ALU_BGTZ; end
            OP_BGEZ: begin ctrl_o.branch = 1'b1; ctrl_o.alu_op = ALU_BGEZ; end
            OP_LW, OP_LB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.mem_byte   = (inst_i == OP_LB);
            end
            OP_SW, OP_SB: begin
                ctrl_o.mem_write_en = 1'b1;
                ctrl_o.alu_src      = 1'b1;
                ctrl_o.alu_op       = ALU_ADD;
                ctrl_o.mem_byte     = (inst_i == OP_SB);
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Registered, valid/ready control decoder between IF/ID and EX with MULT/DIV
// stall, SYSCALL drain-then-halt and illegal-instruction flagging.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES  = 4,
    parameter bit          ENABLE_MULDIV = 1'b1,
    parameter int unsigned MULDIV_LAT    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] inst,
    input  logic [5:0] func,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       reg_dst,
    output logic       jump,
    output logic       branch,
    output logic       mem_write_en,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic       reg_write,
    output logic [5:0] alu_op,
    output logic       link,
    output logic       mem_byte,
    output logic       illegal,
    output logic       halted,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (MULDIV_LAT > DRAIN_CYCLES + 1) ? MULDIV_LAT - 1 : DRAIN_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_LAT - 1);
    localparam logic [CNT_W-1:0] DR_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    ctrl_bundle_t     bundle_q, bundle_d;
    ctrl_bundle_t     dec;
    logic             dec_muldiv, dec_syscall;
    logic             accept;

    ctrl_decode #(.ENABLE_MULDIV(ENABLE_MULDIV)) u_decode (
        .inst_i       (inst),
        .func_i       (func),
        .ctrl_o       (dec),
        .is_muldiv_o  (dec_muldiv),
        .is_syscall_o (dec_syscall)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Leaving a wait state on the edge where the counter steps 1->0 keeps the
    // next accept exactly MULDIV_LAT (or DRAIN_CYCLES) edges after the trigger.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (accept && dec_muldiv && (MULDIV_LAT > 1)) begin
                    state_d = ST_MULDIV_WAIT;
                    cnt_d   = MD_LOAD;
                end else if (accept && dec_syscall) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = DR_LOAD;
                    end
                end
            end
            ST_MULDIV_WAIT: begin
                if (flush || (cnt_q <= CNT_ONE)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DRAIN: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_HALTED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_RUN) && !flush && (!out_valid_q || out_ready);
        busy     = (state_q != ST_RUN);
        halted   = (state_q == ST_HALTED);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (out_ready || flush) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign reg_dst      = bundle_q.reg_dst;
    assign jump         = bundle_q.jump;
    assign branch       = bundle_q.branch;
    assign mem_write_en = bundle_q.mem_write_en;
    assign mem_to_reg   = bundle_q.mem_to_reg;
    assign alu_src      = bundle_q.alu_src;
    assign reg_write    = bundle_q.reg_write;
    assign alu_op       = bundle_q.alu_op;
    assign link         = bundle_q.link;
    assign mem_byte     = bundle_q.mem_byte;
    assign illegal      = bundle_q.illegal;

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
Registered, handshaked successor to the single-cycle main control decoder. It sits between IF/ID and EX. It decodes opcode/func into a control bundle held in one output register with valid/ready flow control. It adds what the old decoder lacks: multi-cycle MULT/DIV stall, a SYSCALL drain-then-halt sequence, illegal-opcode flagging, JAL link and byte-access qualifiers.

Parameters:
DRAIN_CYCLES, 4, cycles after an accepted SYSCALL before halted rises (downstream pipeline depth); legal range 0..15
ENABLE_MULDIV, 1, 1 = MULT/DIV legal and stall the input; 0 = MULT/DIV flagged illegal
MULDIV_LAT, 8, total cycles a MULT/DIV occupies, issue cycle included; legal range ≥1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  opcode/func valid
in_ready  out  1  unit accepts input this cycle
inst  in  6  opcode field [31:26]
func  in  6  function field [5:0]
flush  in  1  squash held output (branch/jump redirect)
out_valid  out  1  control bundle valid
out_ready  in  1  EX accepts bundle
reg_dst, jump, branch, mem_write_en, mem_to_reg, alu_src, reg_write  out  1 each  classic control lines
alu_op  out  6  ALU operation code
link  out  1  JAL: write PC+8 to $31
mem_byte  out  1  LB/SB byte access
illegal  out  1  unrecognised opcode/func in this bundle
halted  out  1  sticky halt
busy  out  1  state != RUN

Behaviour:
- Reset (sync, rst=1 at a posedge): state=RUN; every output 0 (out_valid, all control lines, alu_op=0, halted=0). in_ready then follows the rule below.
- Accept: in_valid && in_ready. in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
- Latency: bundle appears registered 1 cycle after accept. It holds stable while out_valid && !out_ready.
- out_valid next = accept ? 1 : (out_ready || flush) ? 0 : hold. flush beats a same-cycle input, which is not accepted.
- Decode. All unlisted lines are 0; don't-cares are driven 0.
  - R (000000): reg_write, reg_dst=1; alu_op=func.
  - SYSCALL (func 001100): reg_write=0, alu_op=0.
  - MULT 011000 / DIV 011010: reg_write=0.
  - J 000010: jump=1; alu_op=ADD.
  - JAL 000011: jump=1, link=1, reg_write=1; alu_op=ADD.
  - ALU-immediate: reg_write=1, alu_src=1. ADDI 001000→ADD; ADDIU 001001→ADDU; ANDI 001100→AND; ORI 001101→OR; XORI 001110→XOR; SLTI 001010→SLT; LUI 001111→LUI.
  - Branches: branch=1. BEQ 000100→111000; BNE 000101→111001; BLEZ 000110→111010; BGTZ 000111→111011; BGEZ 000001→111100.
  - LW 100011 / LB 100000: reg_write=1, alu_src=1, mem_to_reg=1, alu_op=ADD. LB also sets mem_byte=1.
  - SW 101011 / SB 101000: mem_write_en=1, alu_src=1, alu_op=ADD. SB also sets mem_byte=1.
  - Any other opcode, an R-func outside the package list, or MULT/DIV when ENABLE_MULDIV=0: illegal=1, all write enables 0. Still issued as a valid bundle.
- FSM states: RUN, MULDIV_WAIT, DRAIN, HALTED.
  - RUN→MULDIV_WAIT on accepted MULT/DIV when ENABLE_MULDIV=1 and MULDIV_LAT>1. Counter loads MULDIV_LAT-1 and decrements each cycle; return to RUN when the counter reaches 0. The next accept occurs exactly MULDIV_LAT cycles after the MULT/DIV accept.
  - RUN→DRAIN on accepted SYSCALL. Counter loads DRAIN_CYCLES; at 0 go to HALTED. DRAIN_CYCLES=0 goes straight to HALTED.
  - HALTED: halted=1 sticky; in_ready=0; exits only via rst.
  - flush in MULDIV_WAIT: return to RUN next cycle. flush does not affect DRAIN or HALTED.
- rst mid-operation overrides everything: state RUN, counters 0, out_valid 0.

Decomposition:
- Package ctrl_pkg: opcode/func localparams, alu_op codes (ADD 100000, ADDU 100001, AND 100100, OR 100101, XOR 100110, SLT 101010, LUI 111101, branch codes above), state enum, ctrl_bundle_t packed struct.
- Sub-module ctrl_decode: purely combinational opcode/func → ctrl_bundle_t plus is_muldiv/is_syscall flags. The top holds the FSM, counter and output register.

Test Plan:
- Reset, then stream ADDI, LW, SB, BNE, JAL with out_ready=1 → one bundle per cycle at 1-cycle latency; LW: reg_write=1, alu_src=1, mem_to_reg=1, alu_op=100000; SB: mem_byte=1, mem_write_en=1; BNE: branch=1, alu_op=111001; JAL: link=1, reg_write=1.
- ORI accepted with out_ready held 0 for 3 cycles → bundle stable (alu_op=100101), in_ready=0; first ADD is accepted the cycle out_ready rises.
- MULT, MULDIV_LAT=8, then back-to-back ADD → ADD accepted exactly 8 cycles after MULT; busy=1 for 7 cycles. Repeat with flush in cycle 3 → ADD accepted at cycle 4.
- SYSCALL, DRAIN_CYCLES=4 → halted=1 at the 5th cycle after accept; in_ready stays 0 thereafter; flush has no effect; rst clears halted and all outputs.
- Opcode 111111, and R func 000001 → illegal=1, reg_write=0, mem_write_en=0, out_valid=1. ENABLE_MULDIV=0 with DIV → illegal=1, no stall.
- flush concurrent with in_valid=1 (ADD) while out_valid=1 → out_valid=0 next cycle; ADD not accepted and accepted the following cycle.
